// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: byte-serial command front end for the 7-bit ALU.
// Collects an opcode byte and one or two operand bytes, then drives registered
// A/B/OpSel into the ALU. One cycle later it captures the ALU result and flags
// into a single-entry output register. It also keeps an accumulator and a
// count of completed operations.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an opcode byte
// GET_A  | waiting for the A operand byte
// GET_B  | waiting for the B operand byte
// EXEC   | ALU inputs settled; capture result on the closing edge
// HOLD   | result presented, waiting for the downstream to consume it
module alu_op_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [6:0] out_result,
   output logic [3:0] out_flags,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [6:0] alu_a,
   output logic [6:0] alu_b,
   output logic [2:0] alu_opsel,
   input  logic [6:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       alu_zero,
   input  logic       alu_negative,
   output logic [6:0] acc,
   output logic [7:0] op_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET_A = 3'd1,
      GET_B = 3'd2,
      EXEC  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   in_fire;

   // Byte acceptance only while collecting a command; one result in flight.
   assign in_ready = (state == IDLE) || (state == GET_A) || (state == GET_B);
   assign in_fire  = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and output-valid.
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (in_fire) begin
               state_nxt = in_data[3] ? GET_B : GET_A;
            end
         end
         GET_A: begin
            if (in_fire) begin
               state_nxt = GET_B;
            end
         end
         GET_B: begin
            if (in_fire) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand loading, result capture, accumulator and op counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= 7'd0;
         alu_b      <= 7'd0;
         alu_opsel  <= 3'd0;
         out_result <= 7'd0;
         out_flags  <= 4'd0;
         acc        <= 7'd0;
         op_count   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_fire) begin
                  alu_opsel <= in_data[2:0];
                  // CLR empties the accumulator whether or not it feeds A.
                  if (in_data[4]) begin
                     acc <= 7'd0;
                  end
                  if (in_data[3]) begin
                     alu_a <= in_data[4] ? 7'd0 : acc;
                  end
               end
            end
            GET_A: begin
               if (in_fire) begin
                  alu_a <= in_data[6:0];
               end
            end
            GET_B: begin
               if (in_fire) begin
                  alu_b <= in_data[6:0];
               end
            end
            EXEC: begin
               out_result <= alu_result;
               out_flags  <= {alu_carry, alu_overflow, alu_zero, alu_negative};
               acc        <= alu_result;
               op_count   <= op_count + 8'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the DUT's ALU port,
// transaction-level reference model, directed table plus random ops.
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] out_result;
   logic [3:0] out_flags;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] alu_a;
   logic [6:0] alu_b;
   logic [2:0] alu_opsel;
   logic [6:0] alu_result;
   logic       alu_carry;
   logic       alu_overflow;
   logic       alu_zero;
   logic       alu_negative;
   logic [6:0] acc;
   logic [7:0] op_count;

   int checks = 0;
   int passes = 0;

   // reference state
   int m_acc = 0;
   int m_cnt = 0;

   alu_op_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_result(out_result), .out_flags(out_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .alu_negative(alu_negative),
      .acc(acc), .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 7-bit ALU behaviour: returns {C,V,Z,N, result[6:0]}.
   function automatic logic [10:0] alu_ref(input int op, input int a, input int b);
      int s;
      int sa;
      int sb;
      int sv;
      int r;
      logic c;
      logic v;
      sa = (a >= 64) ? a - 128 : a;
      sb = (b >= 64) ? b - 128 : b;
      c = 1'b0;
      v = 1'b0;
      case (op)
         0: begin
            s = a + b;
            r = s % 128;
            c = (s > 127);
            sv = sa + sb;
            v = (sv > 63) || (sv < -64);
         end
         1: begin
            s = a - b;
            r = (s + 128) % 128;
            c = (a >= b);
            sv = sa - sb;
            v = (sv > 63) || (sv < -64);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 127 - a;
         default: r = 0;
      endcase
      return {c, v, (r == 0), (r >= 64), 7'(r)};
   endfunction

   logic [10:0] alu_env;
   always_comb begin
      alu_env      = alu_ref(int'(alu_opsel), int'(alu_a), int'(alu_b));
      alu_result   = alu_env[6:0];
      alu_carry    = alu_env[10];
      alu_overflow = alu_env[9];
      alu_zero     = alu_env[8];
      alu_negative = alu_env[7];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
   endtask

   // Present a byte and hold it until accepted; returns 1 ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) chk("in_ready_wait", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called 1 ns after the last operand edge: checks EXEC, HOLD and consumption.
   task automatic finish_op(input int ea, input int eb, input int op, input int hold,
                            input bit drive_in,
                            output logic [6:0] got_res, output logic [3:0] got_flags);
      logic [10:0] e;
      e = alu_ref(op, ea, eb);
      chk("exec_out_valid", int'(out_valid), 0);
      chk("exec_in_ready", int'(in_ready), 0);
      if (hold == 0) out_ready = 1'b1;
      @(posedge clk); #1;
      got_res   = out_result;
      got_flags = out_flags;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("result", int'(out_result), int'(e[6:0]));
      chk("flags", int'(out_flags), int'(e[10:7]));
      chk("acc", int'(acc), int'(e[6:0]));
      chk("op_count", int'(op_count), (m_cnt + 1) % 256);
      chk("alu_a", int'(alu_a), ea);
      chk("alu_b", int'(alu_b), eb);
      chk("alu_opsel", int'(alu_opsel), op);
      chk("hold_in_ready", int'(in_ready), 0);
      if (hold > 0) begin
         if (drive_in) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
         end
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_result", int'(out_result), int'(e[6:0]));
            chk("stall_in_ready", int'(in_ready), 0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("consumed_out_valid", int'(out_valid), 0);
      chk("consumed_in_ready", int'(in_ready), 1);
      chk("result_held", int'(out_result), int'(e[6:0]));
      m_acc = int'(e[6:0]);
      m_cnt = (m_cnt + 1) % 256;
   endtask

   task automatic run_op(input logic [7:0] opc, input logic [6:0] a, input logic [6:0] b,
                         input int hold,
                         output logic [6:0] got_res, output logic [3:0] got_flags);
      int ea;
      logic [7:0] ab;
      logic [7:0] bb;
      if (opc[4]) m_acc = 0;
      ea = opc[3] ? m_acc : int'(a);
      ab = {1'($urandom_range(0, 1)), a};
      bb = {1'($urandom_range(0, 1)), b};
      send_byte(opc);
      if (!opc[3]) send_byte(ab);
      send_byte(bb);
      finish_op(ea, int'(b), int'(opc[2:0]), hold, 1'b0, got_res, got_flags);
   endtask

   typedef struct {
      logic [7:0] opc;
      logic [6:0] a;
      logic [6:0] b;
      logic [6:0] res;
      logic [3:0] flags;
   } vec_t;

   vec_t tbl[6];
   logic [6:0] gr;
   logic [3:0] gf;

   initial begin
      tbl[0] = '{8'h00, 7'h05, 7'h03, 7'h08, 4'h0};
      tbl[1] = '{8'h01, 7'h03, 7'h05, 7'h7E, 4'h1};
      tbl[2] = '{8'h01, 7'h05, 7'h05, 7'h00, 4'hA};
      tbl[3] = '{8'h00, 7'h3F, 7'h01, 7'h40, 4'h5};
      tbl[4] = '{8'h0B, 7'h00, 7'h01, 7'h41, 4'h1};
      tbl[5] = '{8'h1B, 7'h00, 7'h22, 7'h22, 4'h0};

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_result", int'(out_result), 0);
      chk("rst_out_flags", int'(out_flags), 0);
      chk("rst_acc", int'(acc), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_opsel", int'(alu_opsel), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].opc, tbl[i].a, tbl[i].b, i % 2, gr, gf);
         chk($sformatf("tbl%0d_result", i), int'(gr), int'(tbl[i].res));
         chk($sformatf("tbl%0d_flags", i), int'(gf), int'(tbl[i].flags));
      end

      // backpressure: in_valid with 0x00 held during a 5-cycle stall
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h03);
      finish_op(5, 3, 0, 5, 1'b1, gr, gf);
      // the held 0x00 opcode is taken on the first IDLE edge
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_opcode_taken_in_ready", int'(in_ready), 1);
      send_byte(8'h07);
      send_byte(8'h01);
      finish_op(7, 1, 0, 0, 1'b0, gr, gf);
      chk("bp_follow_result", int'(gr), 8);

      // reset in GET_B
      send_byte(8'h00);
      send_byte(8'h10);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_acc", int'(acc), 0);
      chk("mid_rst_op_count", int'(op_count), 0);
      chk("mid_rst_alu_a", int'(alu_a), 0);
      chk("mid_rst_result", int'(out_result), 0);
      chk("mid_rst_flags", int'(out_flags), 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 0;
      m_cnt = 0;
      @(posedge clk); #1;
      run_op(8'h00, 7'h02, 7'h02, 0, gr, gf);
      chk("post_rst_result", int'(gr), 4);

      // random ops
      for (int i = 0; i < 60; i++) begin
         run_op(8'($urandom), 7'($urandom), 7'($urandom), int'($urandom_range(0, 3)), gr, gf);
      end

      // 256 reserved ops: op_count wraps to its starting value
      begin
         int start;
         start = m_cnt;
         for (int i = 0; i < 256; i++) begin
            run_op(8'h06, 7'($urandom), 7'($urandom), 0, gr, gf);
            if (i % 64 == 0) begin
               chk("rsv_result", int'(gr), 0);
               chk("rsv_flags", int'(gf), 2);
            end
         end
         chk("wrap_op_count", int'(op_count), start);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
